// File: rtl/rob_commit.sv
// Reorder buffer: allocates tags at dispatch, gathers out-of-order writebacks and
// retires entries strictly in program order onto the CDB feeding the register file.
module rob_commit #(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic [31:0]      alloc_pc,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_val,
  input  logic             predict_fail,
  output logic             cdb_active,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_val,
  output logic [4:0]       cdb_rd_idx,
  output logic [31:0]      cdb_addr,
  output logic [TAG_W-1:0] count
);

  localparam int unsigned      IDX_W     = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       rd_d  [DEPTH];
  logic [31:0]      pc_q  [DEPTH];
  logic [31:0]      pc_d  [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      val_d [DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;
  logic             cdb_active_q, cdb_active_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]      cdb_val_q, cdb_val_d;
  logic [4:0]       cdb_rd_idx_q, cdb_rd_idx_d;
  logic [31:0]      cdb_addr_q, cdb_addr_d;

  logic [IDX_W-1:0] head_idx, tail_idx, wb_idx;
  logic             wb_hit, do_alloc, do_commit;

  // Tags run 1..DEPTH; tag 0 is reserved for "no dependency".
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] tag);
    return (tag == LAST_TAG) ? FIRST_TAG : tag + FIRST_TAG;
  endfunction

  assign head_idx    = IDX_W'(head_q - FIRST_TAG);
  assign tail_idx    = IDX_W'(tail_q - FIRST_TAG);
  assign wb_idx      = IDX_W'(wb_tag - FIRST_TAG);
  assign alloc_ready = (count_q < LAST_TAG);
  assign alloc_tag   = tail_q;

  assign cdb_active  = cdb_active_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_val     = cdb_val_q;
  assign cdb_rd_idx  = cdb_rd_idx_q;
  assign cdb_addr    = cdb_addr_q;
  assign count       = count_q;

  // Next-state: flush dominates; otherwise writeback, alloc and commit act together.
  always_comb begin
    busy_d       = busy_q;
    done_d       = done_q;
    rd_d         = rd_q;
    pc_d         = pc_q;
    val_d        = val_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    cdb_active_d = cdb_active_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_val_d    = cdb_val_q;
    cdb_rd_idx_d = cdb_rd_idx_q;
    cdb_addr_d   = cdb_addr_q;
    wb_hit       = 1'b0;
    do_alloc     = 1'b0;
    do_commit    = 1'b0;
    if (rdy_in) begin
      if (predict_fail) begin
        busy_d       = '0;
        done_d       = '0;
        head_d       = FIRST_TAG;
        tail_d       = FIRST_TAG;
        count_d      = '0;
        cdb_active_d = 1'b0;
      end else begin
        wb_hit    = wb_valid && (wb_tag != '0) && (32'(wb_tag) <= DEPTH) && busy_q[wb_idx];
        do_alloc  = alloc_valid && alloc_ready;
        do_commit = busy_q[head_idx] && done_q[head_idx];
        if (wb_hit) begin
          done_d[wb_idx] = 1'b1;
          val_d[wb_idx]  = wb_val;
        end
        if (do_alloc) begin
          busy_d[tail_idx] = 1'b1;
          done_d[tail_idx] = 1'b0;
          rd_d[tail_idx]   = alloc_rd;
          pc_d[tail_idx]   = alloc_pc;
          tail_d           = next_tag(tail_q);
        end
        cdb_active_d = do_commit;
        // Commit reads registered entry state, so a same-cycle writeback is not visible here.
        if (do_commit) begin
          cdb_tag_d        = head_q;
          cdb_val_d        = val_q[head_idx];
          cdb_rd_idx_d     = rd_q[head_idx];
          cdb_addr_d       = pc_q[head_idx];
          busy_d[head_idx] = 1'b0;
          done_d[head_idx] = 1'b0;
          head_d           = next_tag(head_q);
        end
        if (do_alloc && !do_commit) begin
          count_d = count_q + FIRST_TAG;
        end else if (do_commit && !do_alloc) begin
          count_d = count_q - FIRST_TAG;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      done_q       <= '0;
      head_q       <= FIRST_TAG;
      tail_q       <= FIRST_TAG;
      count_q      <= '0;
      cdb_active_q <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_val_q    <= '0;
      cdb_rd_idx_q <= '0;
      cdb_addr_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      cdb_active_q <= cdb_active_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_val_q    <= cdb_val_d;
      cdb_rd_idx_q <= cdb_rd_idx_d;
      cdb_addr_q   <= cdb_addr_d;
    end
  end

  // Payload storage is qualified by busy/done, so it needs no reset.
  always_ff @(posedge clk_in) begin
    rd_q  <= rd_d;
    pc_q  <= pc_d;
    val_q <= val_d;
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: in-order retire, flush, full/wrap, concurrent
// alloc+commit, pause and asynchronous reset mid-burst.
module tb_rob_commit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_val;
  logic        predict_fail;
  logic        cdb_active;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic [4:0]  cdb_rd_idx;
  logic [31:0] cdb_addr;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  rob_commit #(.DEPTH(15), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .predict_fail(predict_fail),
    .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_rd_idx(cdb_rd_idx), .cdb_addr(cdb_addr), .count(count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    alloc_valid  = 1'b0;
    wb_valid     = 1'b0;
    predict_fail = 1'b0;
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic [31:0] pc);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    alloc_pc    = pc;
  endtask

  task automatic do_wb(input logic [3:0] tag, input logic [31:0] val);
    wb_valid = 1'b1;
    wb_tag   = tag;
    wb_val   = val;
  endtask

  task automatic check_cdb(input string tag, input logic [3:0] t, input logic [4:0] rd,
                           input logic [31:0] val, input logic [31:0] pc);
    check({tag, "_active"}, 32'(cdb_active), 32'd1);
    check({tag, "_tag"}, 32'(cdb_tag), 32'(t));
    check({tag, "_rd"}, 32'(cdb_rd_idx), 32'(rd));
    check({tag, "_val"}, cdb_val, val);
    check({tag, "_addr"}, cdb_addr, pc);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    alloc_rd = '0; alloc_pc = '0; wb_tag = '0; wb_val = '0;
    idle();
    tick(); tick();
    rst_in = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_cdb_active", 32'(cdb_active), 32'd0);
    check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    check("rst_cdb_val", cdb_val, 32'd0);
    check("rst_alloc_tag", 32'(alloc_tag), 32'd1);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);

    // In-order retire of out-of-order results
    do_alloc(5'd3, 32'h100); tick();
    do_alloc(5'd5, 32'h104); tick();
    do_alloc(5'd7, 32'h108); tick();
    idle();
    check("ord_count", 32'(count), 32'd3);
    check("ord_alloc_tag", 32'(alloc_tag), 32'd4);
    do_wb(4'd3, 32'h33); tick();
    check("ord_no_commit_t3", 32'(cdb_active), 32'd0);
    do_wb(4'd1, 32'h11); tick();
    check("ord_wb_latency", 32'(cdb_active), 32'd0);
    do_wb(4'd2, 32'h22); tick();
    check_cdb("ord_c1", 4'd1, 5'd3, 32'h11, 32'h100);
    idle(); tick();
    check_cdb("ord_c2", 4'd2, 5'd5, 32'h22, 32'h104);
    tick();
    check_cdb("ord_c3", 4'd3, 5'd7, 32'h33, 32'h108);
    tick();
    check("ord_idle_active", 32'(cdb_active), 32'd0);
    check("ord_idle_tag_hold", 32'(cdb_tag), 32'd3);
    check("ord_empty_count", 32'(count), 32'd0);

    // Flush with 6 live entries (tags 4..9), 3 of them done
    for (int i = 0; i < 6; i++) begin
      do_alloc(5'(i + 1), 32'(32'h500 + 4 * i)); tick();
    end
    idle();
    check("fl_count6", 32'(count), 32'd6);
    do_wb(4'd5, 32'h55); tick();
    do_wb(4'd6, 32'h66); tick();
    do_wb(4'd7, 32'h77); tick();
    check("fl_no_commit", 32'(cdb_active), 32'd0);
    predict_fail = 1'b1;
    do_wb(4'd4, 32'h44);
    do_alloc(5'd9, 32'h9999);
    tick();
    idle();
    check("fl_active", 32'(cdb_active), 32'd0);
    check("fl_count", 32'(count), 32'd0);
    check("fl_alloc_tag", 32'(alloc_tag), 32'd1);
    do_wb(4'd2, 32'hDEAD); tick();
    idle(); tick();
    check("fl_late_wb_active", 32'(cdb_active), 32'd0);
    check("fl_late_wb_count", 32'(count), 32'd0);

    // Fill to 15 with wrap of the tail pointer
    for (int i = 1; i <= 15; i++) begin
      do_alloc(5'(i), 32'(32'h200 + 4 * i)); tick();
    end
    check("full_count", 32'(count), 32'd15);
    check("full_ready", 32'(alloc_ready), 32'd0);
    check("full_alloc_tag", 32'(alloc_tag), 32'd1);
    do_wb(4'd1, 32'h1111); tick();
    wb_valid = 1'b0;
    check("full_alloc_ignored", 32'(count), 32'd15);
    tick();
    check("full_commit_count", 32'(count), 32'd14);
    check_cdb("full_c1", 4'd1, 5'd1, 32'h1111, 32'h204);
    do_alloc(5'd9, 32'h300); tick();
    idle();
    check("wrap_count", 32'(count), 32'd15);
    check("wrap_alloc_tag", 32'(alloc_tag), 32'd2);
    check("wrap_ready", 32'(alloc_ready), 32'd0);
    check("wrap_late_wb_t2", 32'(cdb_active), 32'd0);

    // Concurrent alloc+commit at count=4
    predict_fail = 1'b1; tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      do_alloc(5'(10 + i), 32'(32'h600 + 4 * i)); tick();
    end
    idle();
    do_wb(4'd1, 32'hA1); tick();
    wb_valid = 1'b0;
    do_alloc(5'd20, 32'h610); tick();
    idle();
    check("c4_count", 32'(count), 32'd4);
    check_cdb("c4_c1", 4'd1, 5'd10, 32'hA1, 32'h600);
    check("c4_alloc_tag", 32'(alloc_tag), 32'd6);

    // Pause with toggling requests
    do_wb(4'd2, 32'hB2); tick();
    idle();
    check("pre_pause_active", 32'(cdb_active), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rdy_in      = 1'b0;
      wb_valid    = i[0];
      wb_tag      = 4'd3;
      wb_val      = 32'hBAD;
      alloc_valid = ~i[0];
      tick();
      check("pause_count", 32'(count), 32'd4);
      check("pause_active", 32'(cdb_active), 32'd0);
    end
    check("pause_cdb_tag", 32'(cdb_tag), 32'd1);
    check("pause_cdb_val", cdb_val, 32'hA1);
    check("pause_alloc_tag", 32'(alloc_tag), 32'd6);
    idle();
    rdy_in = 1'b1;
    tick();
    check_cdb("resume_c2", 4'd2, 5'd11, 32'hB2, 32'h604);
    tick();
    check("resume_t3_pending", 32'(cdb_active), 32'd0);
    check("resume_count", 32'(count), 32'd3);

    // Asynchronous reset with 5 live entries and a commit in flight
    do_alloc(5'd21, 32'h700); tick();
    do_alloc(5'd22, 32'h704); do_wb(4'd3, 32'hC3); tick();
    wb_valid = 1'b0;
    do_alloc(5'd23, 32'h708); tick();
    idle();
    check("mr_count5", 32'(count), 32'd5);
    check("mr_active", 32'(cdb_active), 32'd1);
    #2 rst_in = 1'b1;
    #1;
    check("mr_rst_count", 32'(count), 32'd0);
    check("mr_rst_active", 32'(cdb_active), 32'd0);
    check("mr_rst_cdb_tag", 32'(cdb_tag), 32'd0);
    check("mr_rst_alloc_tag", 32'(alloc_tag), 32'd1);
    tick();
    rst_in = 1'b0;
    do_alloc(5'd0, 32'h800); tick();
    idle();
    do_wb(4'd1, 32'h77); tick();
    idle(); tick();
    check_cdb("mr_rd0_c1", 4'd1, 5'd0, 32'h77, 32'h800);
    check("mr_final_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
